// File: rtl/ctrl_seq_if.sv
// Bundle between a controller and the ctrl_seq sequencer: entry load port, run control, and outputs.
// Zero latency: this interface holds wires only.
// No backpressure: the producer must hold each request for one clock and sample outputs on the clock.
//
// Ports (grouped here and used as modports):
//   master - the controller side. It drives load_*, start, stop, len and loop, and it sees ctrl_out,
//            busy, done, step_idx and err.
//   slave  - the sequencer side. Its directions are the reverse of the master side.
// Optional: when the CTRL_SEQ_STEP_EN macro is defined, the interface also carries step_mode and step_go.
interface ctrl_seq_if #(
    parameter int DEPTH  = 16,
    parameter int CW_W   = 17,
    parameter int HOLD_W = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [CW_W-1:0]   load_word;
    logic [HOLD_W-1:0] load_hold;
    logic              start;
    logic              stop;
    logic [AW:0]       len;
    logic              loop;
    logic [CW_W-1:0]   ctrl_out;
    logic              busy;
    logic              done;
    logic [AW-1:0]     step_idx;
    logic              err;
`ifdef CTRL_SEQ_STEP_EN
    logic              step_mode;
    logic              step_go;

    modport master (
        output load_en, load_addr, load_word, load_hold,
        output start, stop, len, loop, step_mode, step_go,
        input  ctrl_out, busy, done, step_idx, err
    );
    modport slave (
        input  load_en, load_addr, load_word, load_hold,
        input  start, stop, len, loop, step_mode, step_go,
        output ctrl_out, busy, done, step_idx, err
    );
`else
    modport master (
        output load_en, load_addr, load_word, load_hold,
        output start, stop, len, loop,
        input  ctrl_out, busy, done, step_idx, err
    );
    modport slave (
        input  load_en, load_addr, load_word, load_hold,
        input  start, stop, len, loop,
        output ctrl_out, busy, done, step_idx, err
    );
`endif
endinterface

// File: rtl/ctrl_seq.sv
// Plays a stored table of datapath control words. Each entry stays on the output for its hold+1 cycles.
// Latency: the first word appears one clock after an accepted start, and every output is registered.
// No backpressure: the sequencer runs freely. Only stop, rst or (with the step option) step_go change the pace.
//
// Ports:
//   clk, rst - rising-edge clock and synchronous active-high reset. Reset leaves the entry storage intact.
//   bus      - a ctrl_seq_if.slave port. It carries load_*, start, stop, len, loop, ctrl_out, busy,
//              done, step_idx and err.
// Optional feature macro: CTRL_SEQ_STEP_EN. It adds step_mode and step_go for single-stepping.
//   When step_mode=1, an entry advances only on a step_go cycle and the hold counts are ignored.
module ctrl_seq #(
    parameter int DEPTH  = 16,
    parameter int CW_W   = 17,
    parameter int HOLD_W = 4
) (
    input logic     clk,
    input logic     rst,
    ctrl_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX0    = '0;

    // Entry storage. It has no reset, so a loaded table survives rst.
    logic [CW_W-1:0]   word_mem [DEPTH];
    logic [HOLD_W-1:0] hold_mem [DEPTH];

    logic [1:0]        state_q,    state_d;
    logic [CW_W-1:0]   ctrl_q,     ctrl_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [AW-1:0]     idx_q,      idx_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [AW:0]       len_q,      len_d;
    logic              loop_q,     loop_d;

    logic              len_ok;
    logic              at_last;
    logic              entry_end;
    logic [AW-1:0]     next_idx;

    // len is AW+1 bits wide so that DEPTH itself can be represented.
    // Both ends of the legal range are checked here.
    assign len_ok   = (bus.len != '0) && (bus.len <= LEN_MAX);
    // The current entry is the last one when idx+1 equals len.
    // The comparison is done at AW+1 bits so that len=DEPTH does not wrap.
    assign at_last  = (({1'b0, idx_q} + 1'b1) == len_q);
    assign next_idx = idx_q + 1'b1;

`ifdef CTRL_SEQ_STEP_EN
    assign entry_end = bus.step_mode ? bus.step_go : (hold_cnt_q == '0);
`else
    assign entry_end = (hold_cnt_q == '0);
`endif

    // Entry writes are accepted outside RUN only, so the table being played never changes mid-run.
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q != S_RUN)) begin
            word_mem[bus.load_addr] <= bus.load_word;
            hold_mem[bus.load_addr] <= bus.load_hold;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        len_d      = len_q;
        loop_d     = loop_q;

        case (state_q)
            S_IDLE: begin
                ctrl_d     = '0;
                busy_d     = 1'b0;
                idx_d      = '0;
                hold_cnt_d = '0;
                // When stop and start arrive together, stop takes priority: no run starts and no error is flagged.
                if (bus.start && !bus.stop) begin
                    if (len_ok) begin
                        state_d    = S_RUN;
                        ctrl_d     = word_mem[IDX0];
                        busy_d     = 1'b1;
                        hold_cnt_d = hold_mem[IDX0];
                        len_d      = bus.len;
                        loop_d     = bus.loop;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    state_d    = S_IDLE;
                    ctrl_d     = '0;
                    busy_d     = 1'b0;
                    idx_d      = '0;
                    hold_cnt_d = '0;
                end else if (entry_end) begin
                    if (at_last && !loop_q) begin
                        state_d    = S_DONE;
                        ctrl_d     = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        idx_d      = '0;
                        hold_cnt_d = '0;
                    end else if (at_last) begin
                        // In loop mode, wrap straight back to entry 0 with no gap cycle.
                        idx_d      = '0;
                        ctrl_d     = word_mem[IDX0];
                        hold_cnt_d = hold_mem[IDX0];
                    end else begin
                        idx_d      = next_idx;
                        ctrl_d     = word_mem[next_idx];
                        hold_cnt_d = hold_mem[next_idx];
                    end
                end else if (hold_cnt_q != '0) begin
                    // The guard matters only in step mode. There the counter can be at zero
                    // while the output waits for step_go, and it must not wrap around.
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                ctrl_d     = '0;
                busy_d     = 1'b0;
                idx_d      = '0;
                hold_cnt_d = '0;
            end

            default: begin
                state_d    = S_IDLE;
                ctrl_d     = '0;
                busy_d     = 1'b0;
                idx_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
        end
    end

    assign bus.ctrl_out = ctrl_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.step_idx = idx_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq. Inputs are driven on the falling edge, and outputs are sampled there too.
module tb_ctrl_seq;
    localparam int DEPTH  = 16;
    localparam int CW_W   = 17;
    localparam int HOLD_W = 4;
    localparam int AW     = $clog2(DEPTH);

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ctrl_seq_if #(.DEPTH(DEPTH), .CW_W(CW_W), .HOLD_W(HOLD_W)) bus ();

    ctrl_seq #(.DEPTH(DEPTH), .CW_W(CW_W), .HOLD_W(HOLD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_entry(input logic [AW-1:0] a, input logic [CW_W-1:0] w, input logic [HOLD_W-1:0] h);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_word = w;
        bus.load_hold = h;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // After this returns, the outputs show the first cycle of the run.
    task automatic start_run(input logic [AW:0] l, input logic lp);
        bus.start = 1'b1;
        bus.len   = l;
        bus.loop  = lp;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic load_base();
        load_entry(4'd0, 17'h00001, 4'd0);
        load_entry(4'd1, 17'h00002, 4'd2);
        load_entry(4'd2, 17'h00003, 4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ctrl_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.step_idx !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ctrl=%h busy=%b done=%b err=%b idx=%0d, all must be 0",
                     bus.ctrl_out, bus.busy, bus.done, bus.err, bus.step_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ctrl_out !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b ctrl=%h, need 0/0", bus.busy, bus.ctrl_out);
        end
    endtask

    task automatic test_single_run();
        int exp_w[5];
        int exp_i[5];
        exp_w = '{1, 2, 2, 2, 3};
        exp_i = '{0, 1, 1, 1, 2};
        start_run(5'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ctrl_out !== 17'(exp_w[i]) || bus.step_idx !== 4'(exp_i[i]) ||
                bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL single_run_c%0d: ctrl=%h idx=%0d busy=%b done=%b, need ctrl=%h idx=%0d busy=1 done=0",
                         i + 1, bus.ctrl_out, bus.step_idx, bus.busy, bus.done, exp_w[i], exp_i[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.ctrl_out !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_run_done: done=%b ctrl=%h busy=%b, need 1/0/0", bus.done, bus.ctrl_out, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle: done=%b, need 0", bus.done);
        end
    endtask

    task automatic test_loop_stop();
        int exp_w[8];
        exp_w = '{1, 2, 2, 2, 3, 1, 2, 2};
        start_run(5'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.ctrl_out !== 17'(exp_w[i]) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL loop_c%0d: ctrl=%h busy=%b done=%b, need ctrl=%h busy=1 done=0",
                         i + 1, bus.ctrl_out, bus.busy, bus.done, exp_w[i]);
            end
            if (i == 7) bus.stop = 1'b1;
            @(negedge clk);
        end
        bus.stop = 1'b0;
        checks++;
        if (bus.ctrl_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== '0) begin
            failures++;
            $display("FAIL loop_stop: ctrl=%h busy=%b done=%b idx=%0d, need all 0",
                     bus.ctrl_out, bus.busy, bus.done, bus.step_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_len_err();
        logic [AW:0] bad[2];
        bad = '{5'd0, 5'd17};
        for (int k = 0; k < 2; k++) begin
            start_run(bad[k], 1'b0);
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL len_err_len%0d: err=%b busy=%b, need 1/0", bad[k], bus.err, bus.busy);
            end
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL len_err_pulse_len%0d: err=%b busy=%b, need 0/0", bad[k], bus.err, bus.busy);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        bus.stop = 1'b1;
        start_run(5'd3, 1'b0);
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_valid: busy=%b err=%b, need 0/0", bus.busy, bus.err);
        end
        bus.stop = 1'b1;
        start_run(5'd0, 1'b0);
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_badlen: busy=%b err=%b, need 0/0", bus.busy, bus.err);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        start_run(5'd3, 1'b0);
        start_run(5'd0, 1'b0);
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.ctrl_out !== 17'h2) begin
            failures++;
            $display("FAIL start_in_run: err=%b busy=%b ctrl=%h, need 0/1/00002", bus.err, bus.busy, bus.ctrl_out);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL run_done_c6: done=%b, need 1", bus.done);
        end
        start_run(5'd3, 1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done: busy=%b err=%b, need 0/0", bus.busy, bus.err);
        end
        @(negedge clk);
    endtask

    task automatic test_load_in_run();
        logic seen;
        start_run(5'd3, 1'b0);
        load_entry(4'd0, 17'h1FFFF, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL load_run_done: done=0 within 20 cycles, need done=1");
        end
        @(negedge clk);
        start_run(5'd3, 1'b0);
        checks++;
        if (bus.ctrl_out !== 17'h00001) begin
            failures++;
            $display("FAIL load_in_run_ignored: ctrl=%h, need 00001", bus.ctrl_out);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL load_rerun_done: done=%b, need 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_run_reset();
        start_run(5'd3, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.ctrl_out !== 17'h2) begin
            failures++;
            $display("FAIL pre_reset_c2: ctrl=%h, need 00002", bus.ctrl_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.ctrl_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.step_idx !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: ctrl=%h busy=%b done=%b err=%b idx=%0d, need all 0",
                     bus.ctrl_out, bus.busy, bus.done, bus.err, bus.step_idx);
        end
        @(negedge clk);
        start_run(5'd3, 1'b0);
        checks++;
        if (bus.ctrl_out !== 17'h1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL replay_c1: ctrl=%h busy=%b, need 00001/1", bus.ctrl_out, bus.busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.ctrl_out !== 17'h3 || bus.step_idx !== 4'd2) begin
            failures++;
            $display("FAIL replay_c5: ctrl=%h idx=%0d, need 00003/2", bus.ctrl_out, bus.step_idx);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL replay_done: done=%b, need 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_max_hold();
        load_entry(4'd0, 17'h0AAAA, 4'd15);
        start_run(5'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.ctrl_out !== 17'h0AAAA || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL max_hold_c%0d: ctrl=%h busy=%b, need 0aaaa/1", i + 1, bus.ctrl_out, bus.busy);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.ctrl_out !== '0) begin
            failures++;
            $display("FAIL max_hold_done: done=%b ctrl=%h, need 1/0", bus.done, bus.ctrl_out);
        end
        @(negedge clk);
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) load_entry(4'(i), 17'(32'h100 + i), 4'd0);
        start_run(5'd16, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.ctrl_out !== 17'(32'h100 + i) || bus.step_idx !== 4'(i)) begin
                failures++;
                $display("FAIL full_depth_c%0d: ctrl=%h idx=%0d, need ctrl=%h idx=%0d",
                         i + 1, bus.ctrl_out, bus.step_idx, 32'h100 + i, i);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_depth_done: done=%b busy=%b, need 1/0", bus.done, bus.busy);
        end
        @(negedge clk);
    endtask

`ifdef CTRL_SEQ_STEP_EN
    task automatic test_step_mode();
        load_entry(4'd0, 17'h00011, 4'd0);
        load_entry(4'd1, 17'h00022, 4'd0);
        bus.step_mode = 1'b1;
        start_run(5'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.ctrl_out !== 17'h00011 || bus.step_idx !== 4'd0) begin
                failures++;
                $display("FAIL step_hold_c%0d: ctrl=%h idx=%0d, need 00011/0", i + 1, bus.ctrl_out, bus.step_idx);
            end
            if (i == 9) bus.step_go = 1'b1;
            @(negedge clk);
        end
        bus.step_go = 1'b0;
        checks++;
        if (bus.ctrl_out !== 17'h00022 || bus.step_idx !== 4'd1) begin
            failures++;
            $display("FAIL step_advance: ctrl=%h idx=%0d, need 00022/1", bus.ctrl_out, bus.step_idx);
        end
        bus.step_go = 1'b1;
        @(negedge clk);
        bus.step_go = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL step_done: done=%b, need 1", bus.done);
        end
        bus.step_mode = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_word = '0;
        bus.load_hold = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.len       = '0;
        bus.loop      = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
        bus.step_mode = 1'b0;
        bus.step_go   = 1'b0;
`endif
        test_reset();
        load_base();
        test_single_run();
        test_loop_stop();
        test_len_err();
        test_start_stop_idle();
        test_start_ignored();
        test_load_in_run();
        test_mid_run_reset();
        test_max_hold();
        test_full_depth();
`ifdef CTRL_SEQ_STEP_EN
        test_step_mode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter DEPTH, default 16, number of control-word entries (power of two, 2..256); AW = clog2(DEPTH).
REQ-002 Parameter CW_W, default 17, control-word width (datapath control bundle: regDst..branchAddrSel).
REQ-003 Parameter HOLD_W, default 4, width of the per-entry hold count.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  write load_word/load_hold into entry load_addr.
REQ-007 load_addr  input  AW  entry index for load.
REQ-008 load_word  input  CW_W  control word to store.
REQ-009 load_hold  input  HOLD_W  extra cycles to hold the entry (entry lasts load_hold+1 cycles).
REQ-010 start  input  1  request to begin a run.
REQ-011 stop  input  1  abort request.
REQ-012 len  input  AW+1  number of entries to play, 1..DEPTH, sampled with start.
REQ-013 loop  input  1  wrap to entry 0 after the last entry instead of finishing, sampled with start.
REQ-014 ctrl_out  output  CW_W  registered control word driven to the datapath.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 step_idx  output  AW  index of the entry currently on ctrl_out.
REQ-018 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-020 IDLE + start + len in 1..DEPTH + no stop -> RUN next cycle; ctrl_out=word[0], step_idx=0, busy=1.
REQ-021 IDLE + start + (len==0 or len>DEPTH) -> stay IDLE, err=1 for one cycle.
REQ-022 In RUN each entry SHALL stay on ctrl_out for exactly hold+1 cycles, then advance to step_idx+1.
REQ-023 End of entry len-1 with loop=0 -> DONE: ctrl_out=0, busy=0, done=1 for that single cycle.
REQ-024 End of entry len-1 with loop=1 -> wrap to entry 0 with no gap cycle; done not asserted.
REQ-025 stop in RUN -> IDLE next cycle, ctrl_out=0, busy=0, step_idx=0, done=0.
REQ-026 start in RUN or DONE SHALL be ignored (no err); start and stop together in IDLE -> stop wins, no run, no err.
REQ-027 load_en SHALL write in IDLE and DONE only; load_en in RUN SHALL be ignored.
REQ-028 Hold counter SHALL use HOLD_W bits; hold=2^HOLD_W-1 gives 2^HOLD_W cycles, no overflow.
REQ-029 Outside RUN, ctrl_out SHALL be all zeros (datapath NOP).

Reset
REQ-030 rst SHALL force IDLE, ctrl_out=0, busy=0, done=0, err=0, step_idx=0, hold counter=0, including mid-run.
REQ-031 rst SHALL NOT clear entry storage; contents persist across reset.

Configuration
REQ-032 Macro CTRL_SEQ_STEP_EN defined: add inputs step_mode (1) and step_go (1); when step_mode=1 in RUN, the entry advances only on a cycle with step_go=1, and hold counts are ignored.
REQ-033 CTRL_SEQ_STEP_EN undefined: step_mode/step_go ports absent; always free-running per REQ-022.

Verification
REQ-034 Load 3 entries (0x00001/h0, 0x00002/h2, 0x00003/h0), start len=3 loop=0 -> ctrl_out 1,2,2,2,3 over 5 cycles, then done=1 with ctrl_out=0.
REQ-035 Same load, loop=1 -> sequence 1,2,2,2,3,1,2,... with no gap; stop at cycle 8 -> ctrl_out=0, busy=0 next cycle, no done.
REQ-036 start with len=0, then with len=17 (DEPTH=16) -> err pulses each time, busy stays 0.
REQ-037 rst asserted at cycle 2 of a run -> next cycle all outputs 0; restart with len=3 replays original entries.
REQ-038 load_en of entry 0 = 0x1FFFF during RUN -> ignored; next run still outputs 0x00001 first.
REQ-039 With CTRL_SEQ_STEP_EN, step_mode=1: ctrl_out stays on entry 0 for 10 cycles until step_go pulses, then shows entry 1.
